// File: rtl/write_sram_burst.sv
// Burst SRAM writer: takes one block address, drains BEATS words from the block FIFO and
// writes each to SRAM at {block, beat}. Optional even-parity bit under WRITE_SRAM_PARITY_EN.
module write_sram_burst #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int BEATS      = 4,
    localparam int BW        = $clog2(BEATS),
`ifdef WRITE_SRAM_PARITY_EN
    localparam int OUT_W     = DATA_WIDTH + 1
`else
    localparam int OUT_W     = DATA_WIDTH
`endif
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [ADDR_WIDTH-1:0]    i_blk_addr,
    input  logic                     i_blk_vld,
    output logic                     o_blk_rdy,
    input  logic [DATA_WIDTH-1:0]    i_fifo_data,
    input  logic                     i_fifo_empty,
    output logic                     o_fifo_ren,
    output logic [ADDR_WIDTH+BW-1:0] o_sram_addr,
    output logic                     o_sram_w_vld,
    output logic [OUT_W-1:0]         o_sram_data,
    output logic                     o_busy,
    output logic                     o_done
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                     state_q;
    logic [ADDR_WIDTH-1:0]      blk_q;
    logic [BW-1:0]              beat_q;
    logic [BW-1:0]              beat_d;
    logic [ADDR_WIDTH+BW-1:0]   sram_addr_q;
    logic [ADDR_WIDTH+BW-1:0]   sram_addr_d;
    logic                       sram_w_vld_q;
    logic                       done_q;
    logic                       fifo_ren;
    logic                       last_beat;

    always_comb begin
        fifo_ren    = (state_q == S_BURST) && !i_fifo_empty;
        last_beat   = (beat_q == BW'(BEATS - 1));
        beat_d      = beat_q + 1'b1;
        sram_addr_d = {blk_q, beat_q};
    end

    // FSM and write-stage registers; the beat counter wraps to 0 on its own after the last beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            blk_q        <= '0;
            beat_q       <= '0;
            sram_addr_q  <= '0;
            sram_w_vld_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            sram_w_vld_q <= fifo_ren;
            done_q       <= fifo_ren && last_beat;
            if (fifo_ren) begin
                sram_addr_q <= sram_addr_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (i_blk_vld) begin
                        blk_q   <= i_blk_addr;
                        beat_q  <= '0;
                        state_q <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (fifo_ren) begin
                        beat_q <= beat_d;
                        if (last_beat) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_blk_rdy    = (state_q == S_IDLE);
    assign o_busy       = (state_q == S_BURST);
    assign o_fifo_ren   = fifo_ren;
    assign o_sram_addr  = sram_addr_q;
    assign o_sram_w_vld = sram_w_vld_q;
    assign o_done       = done_q;

    // FIFO data arrives one cycle after the read, lining up with the registered write strobe.
`ifdef WRITE_SRAM_PARITY_EN
    assign o_sram_data = {^i_fifo_data, i_fifo_data};
`else
    assign o_sram_data = i_fifo_data;
`endif

endmodule

// File: tb/tb_write_sram_burst.sv
// Bench for write_sram_burst: table-driven bursts, hand-written corner sequences and a
// randomized run against a queue-based reference of the expected SRAM write stream.
module tb_write_sram_burst;

`ifdef WRITE_SRAM_PARITY_EN
    localparam int OW = 65;
`else
    localparam int OW = 64;
`endif

    logic          i_clk;
    logic          i_rst;
    logic [7:0]    i_blk_addr;
    logic          i_blk_vld;
    logic          o_blk_rdy;
    logic [63:0]   i_fifo_data;
    logic          i_fifo_empty;
    logic          o_fifo_ren;
    logic [9:0]    o_sram_addr;
    logic          o_sram_w_vld;
    logic [OW-1:0] o_sram_data;
    logic          o_busy;
    logic          o_done;

    write_sram_burst dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_blk_addr   (i_blk_addr),
        .i_blk_vld    (i_blk_vld),
        .o_blk_rdy    (o_blk_rdy),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_ren   (o_fifo_ren),
        .o_sram_addr  (o_sram_addr),
        .o_sram_w_vld (o_sram_w_vld),
        .o_sram_data  (o_sram_data),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // FIFO model: words pushed by the stimulus, read data valid one cycle after the read enable.
    logic [63:0] mem [0:1023];
    int          wp = 0;
    int          rp = 0;
    logic        hold_empty;

    assign i_fifo_empty = hold_empty || (rp == wp);

    always @(posedge i_clk) begin
        if (o_fifo_ren) begin
            i_fifo_data <= mem[rp[9:0]];
            rp          <= rp + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [63:0] w);
        mem[wp[9:0]] = w;
        wp++;
    endtask

    function automatic logic [127:0] exp_d(input logic [63:0] w);
`ifdef WRITE_SRAM_PARITY_EN
        return 128'({^w, w});
`else
        return 128'(w);
`endif
    endfunction

    typedef struct {
        logic [7:0]        blk;
        logic [15:0]       mask;      // bit c: FIFO forced empty on burst cycle c
        int                done_cyc;
        logic [3:0][63:0]  words;
    } vec_t;

    vec_t tbl [4];

    logic [9:0]  qa [$];
    logic        ql [$];
    logic [63:0] qd [$];

    initial begin
        int          nw;
        logic [9:0]  ea;
        logic [63:0] bw [8];
        logic [7:0]  a;
        logic        hs;
        int          blk_i;
        int          written;
        int          nblk;

        i_rst = 1'b1; i_blk_addr = '0; i_blk_vld = 1'b0; hold_empty = 1'b0;
        i_fifo_data = '0;

        tbl[0].blk = 8'h2A; tbl[0].mask = 16'h0000; tbl[0].done_cyc = 5;
        tbl[1].blk = 8'h05; tbl[1].mask = 16'h000C; tbl[1].done_cyc = 7;
        tbl[2].blk = 8'hFF; tbl[2].mask = 16'h0002; tbl[2].done_cyc = 6;
        tbl[3].blk = 8'h00; tbl[3].mask = 16'h0012; tbl[3].done_cyc = 7;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                tbl[i].words[k] = {$urandom, $urandom};
        tbl[0].words[0] = 64'h1;
        tbl[0].words[1] = 64'h3;

        // Reset state
        tick(); tick();
        check("rst_rdy",   128'(o_blk_rdy), 128'(1));
        check("rst_busy",  128'(o_busy), 128'(0));
        check("rst_ren",   128'(o_fifo_ren), 128'(0));
        check("rst_wvld",  128'(o_sram_w_vld), 128'(0));
        check("rst_addr",  128'(o_sram_addr), 128'(0));
        check("rst_done",  128'(o_done), 128'(0));
        i_rst = 1'b0;

        // Idle with a non-empty FIFO: never read
        for (int k = 0; k < 4; k++) push(tbl[0].words[k]);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_ren",  128'(o_fifo_ren), 128'(0));
            check("idle_wvld", 128'(o_sram_w_vld), 128'(0));
        end

        // Table-driven bursts with per-cycle empty masks
        for (int i = 0; i < 4; i++) begin
            nw = 0;
            if (i != 0) for (int k = 0; k < 4; k++) push(tbl[i].words[k]);
            i_blk_addr = tbl[i].blk; i_blk_vld = 1'b1; hold_empty = tbl[i].mask[0];
            #1;
            check("tbl_hs_rdy", 128'(o_blk_rdy), 128'(1));
            for (int c = 1; c <= 10; c++) begin
                tick();
                i_blk_vld = 1'b0; hold_empty = tbl[i].mask[c];
                #1;
                if (o_sram_w_vld) begin
                    if (nw < 4) begin
                        ea = {tbl[i].blk, nw[1:0]};
                        check("tbl_addr", 128'(o_sram_addr), 128'(ea));
                        check("tbl_data", 128'(o_sram_data), exp_d(tbl[i].words[nw]));
                    end else begin
                        check("tbl_extra_write", 128'(1), 128'(0));
                    end
                    nw++;
                end
                check("tbl_done", 128'(o_done), 128'(c == tbl[i].done_cyc));
                if (c == 3) check("tbl_busy", 128'(o_busy), 128'(1));
            end
            check("tbl_nwrites", 128'(nw), 128'(4));
            check("tbl_rdy_end", 128'(o_blk_rdy), 128'(1));
        end
        hold_empty = 1'b0;

        // Back-to-back blocks 0x01, 0x02 with valid held high
        nw = 0;
        for (int k = 0; k < 8; k++) begin bw[k] = {$urandom, $urandom}; push(bw[k]); end
        i_blk_addr = 8'h01; i_blk_vld = 1'b1; #1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) i_blk_addr = 8'h02;
            if (c == 6) i_blk_vld = 1'b0;
            #1;
            if (c == 3) check("b2b_rdy_c3", 128'(o_blk_rdy), 128'(0));
            if (c == 5) check("b2b_rdy_c5", 128'(o_blk_rdy), 128'(1));
            check("b2b_wvld", 128'(o_sram_w_vld),
                  128'((c >= 2 && c <= 5) || (c >= 7 && c <= 10)));
            if (o_sram_w_vld && nw < 8) begin
                check("b2b_addr", 128'(o_sram_addr), 128'(10'(4 + nw)));
                check("b2b_data", 128'(o_sram_data), exp_d(bw[nw]));
                nw++;
            end
        end
        check("b2b_nwrites", 128'(nw), 128'(8));

        // Reset after two beats of block 0x10, then block 0x11
        push(64'hAAAA_0000); push(64'hAAAA_0001);
        i_blk_addr = 8'h10; i_blk_vld = 1'b1; #1;
        tick(); i_blk_vld = 1'b0;
        tick(); check("rst_b0_addr", 128'(o_sram_addr), 128'(10'h040));
        tick(); check("rst_b1_addr", 128'(o_sram_addr), 128'(10'h041));
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("rst_mid_rdy",  128'(o_blk_rdy), 128'(1));
        check("rst_mid_busy", 128'(o_busy), 128'(0));
        check("rst_mid_addr", 128'(o_sram_addr), 128'(0));
        for (int k = 0; k < 4; k++) begin bw[k] = {$urandom, $urandom}; push(bw[k]); end
        nw = 0;
        i_blk_addr = 8'h11; i_blk_vld = 1'b1; #1;
        for (int c = 1; c <= 8; c++) begin
            tick(); i_blk_vld = 1'b0; #1;
            if (o_sram_w_vld) begin
                if (nw < 4) begin
                    check("rst_new_addr", 128'(o_sram_addr), 128'(10'(10'h044 + nw)));
                    check("rst_new_data", 128'(o_sram_data), exp_d(bw[nw]));
                end else begin
                    check("rst_extra_write", 128'(1), 128'(0));
                end
                nw++;
            end
        end
        check("rst_new_nwrites", 128'(nw), 128'(4));

        // Randomized run against the expected write stream
        nblk = 40;
        for (int k = 0; k < nblk * 4; k++) begin
            bw[0] = {$urandom, $urandom};
            push(bw[0]);
            qd.push_back(bw[0]);
        end
        blk_i = 0; written = 0;
        for (int c = 0; c < 4000 && written < nblk * 4; c++) begin
            if (o_sram_w_vld) begin
                if (qa.size() == 0) begin
                    check("rnd_extra_write", 128'(1), 128'(0));
                end else begin
                    check("rnd_addr", 128'(o_sram_addr), 128'(qa.pop_front()));
                    check("rnd_data", 128'(o_sram_data), exp_d(qd.pop_front()));
                    check("rnd_done", 128'(o_done), 128'(ql.pop_front()));
                end
                written++;
            end else begin
                check("rnd_done_idle", 128'(o_done), 128'(0));
            end
            hold_empty = ($urandom_range(0, 3) == 0);
            if (!i_blk_vld && blk_i < nblk && $urandom_range(0, 1) == 0) begin
                a = 8'($urandom);
                i_blk_addr = a; i_blk_vld = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    qa.push_back({a, 2'(b)});
                    ql.push_back(b == 3);
                end
            end
            #1;
            hs = i_blk_vld && o_blk_rdy;
            tick();
            if (hs) begin i_blk_vld = 1'b0; blk_i++; end
        end
        check("rnd_nwrites", 128'(written), 128'(nblk * 4));
        hold_empty = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
